// File: rtl/rgb2gray_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rgb2gray_pipe
//
// Fully pipelined RGB -> grayscale converter. Each accepted pixel is weighted
// by one of four coefficient triples, chosen per pixel by 'mode':
//   0 = BT.601, 1 = BT.709, 2 = equal average, 3 = runtime custom weights.
// Coefficients are unsigned Q0.COEF_WIDTH. The weighted sum is rounded to
// nearest, scaled back by COEF_WIDTH bits and clamped to PIX_WIDTH bits.
//
// Pipeline (3 register stages, latency 3 from acceptance to dout_valid):
//   S1: capture R/G/B and the coefficient triple selected by mode
//   S2: three PIX_WIDTH x COEF_WIDTH products
//   S3: sum + round + shift + clamp into the output register
//
// A single global stall keeps every stage in lock-step with the output:
// stages advance only when the output register is empty or being consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   din_valid / din_ready      input pixel handshake
//   R, G, B                    input channels (PIX_WIDTH each)
//   mode                       weighting select, bound to the pixel at S1
//   cfg_we, cfg_cr/cg/cb       custom coefficient write port
//   dout_valid / dout_ready    output pixel handshake
//   grayscale                  gray result (PIX_WIDTH)
//   dout_sat                   result was clamped to all-ones
// -----------------------------------------------------------------------------
module rgb2gray_pipe #(
    parameter int PIX_WIDTH  = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [PIX_WIDTH-1:0]  R,
    input  logic [PIX_WIDTH-1:0]  G,
    input  logic [PIX_WIDTH-1:0]  B,
    input  logic [1:0]            mode,
    input  logic                  cfg_we,
    input  logic [COEF_WIDTH-1:0] cfg_cr,
    input  logic [COEF_WIDTH-1:0] cfg_cg,
    input  logic [COEF_WIDTH-1:0] cfg_cb,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [PIX_WIDTH-1:0]  grayscale,
    output logic                  dout_sat
);

    localparam int NCH    = 3;                      // channel order: R, G, B
    localparam int PROD_W = PIX_WIDTH + COEF_WIDTH;
    localparam int SUM_W  = PROD_W + 2;             // room for three products

    // round(k * 2^COEF_WIDTH) with k given in parts per million. A weight
    // that would round up to 1.0 is pinned to the largest representable
    // fraction since the format has no integer bit.
    function automatic logic [COEF_WIDTH-1:0] coef_from_ppm(input longint unsigned ppm);
        longint unsigned scaled;
        longint unsigned one;
        one    = 64'd1 << COEF_WIDTH;
        scaled = (ppm * one + 64'd500000) / 64'd1000000;
        if (scaled > one - 64'd1) begin
            scaled = one - 64'd1;
        end
        return scaled[COEF_WIDTH-1:0];
    endfunction

    localparam logic [COEF_WIDTH-1:0] C601_R = coef_from_ppm(64'd299000);
    localparam logic [COEF_WIDTH-1:0] C601_G = coef_from_ppm(64'd587000);
    localparam logic [COEF_WIDTH-1:0] C601_B = coef_from_ppm(64'd114000);
    localparam logic [COEF_WIDTH-1:0] C709_R = coef_from_ppm(64'd212600);
    localparam logic [COEF_WIDTH-1:0] C709_G = coef_from_ppm(64'd715200);
    localparam logic [COEF_WIDTH-1:0] C709_B = coef_from_ppm(64'd72200);
    localparam logic [COEF_WIDTH-1:0] CAVG   = coef_from_ppm(64'd333333);

    localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1) << (COEF_WIDTH - 1);
    localparam logic [SUM_W-1:0] PIX_MAX    = SUM_W'((64'd1 << PIX_WIDTH) - 64'd1);

    // ------------------------------------------------------------------
    // Global stall. Every stage moves together, so bubbles stay in place
    // and at most three pixels are ever held inside.
    // ------------------------------------------------------------------
    logic advance;
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic dout_valid_reg;

    assign advance   = !dout_valid_reg || dout_ready;
    assign din_ready = advance;

    // Per-channel views of the inputs so the datapath can be generated.
    logic [PIX_WIDTH-1:0]  din_pix   [NCH];
    logic [COEF_WIDTH-1:0] cfg_coef  [NCH];
    logic [COEF_WIDTH-1:0] cust_coef [NCH];
    logic [COEF_WIDTH-1:0] coef_sel  [NCH];
    logic [PROD_W-1:0]     prod_bus  [NCH];

    assign din_pix[0]  = R;
    assign din_pix[1]  = G;
    assign din_pix[2]  = B;
    assign cfg_coef[0] = cfg_cr;
    assign cfg_coef[1] = cfg_cg;
    assign cfg_coef[2] = cfg_cb;

    // Coefficient triple for the pixel presented this cycle. The custom
    // registers are read before any write on this edge takes effect, so a
    // pixel accepted alongside cfg_we sees the previous custom weights.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            coef_sel[i] = '0;
        end
        case (mode)
            2'd0: begin
                coef_sel[0] = C601_R;
                coef_sel[1] = C601_G;
                coef_sel[2] = C601_B;
            end
            2'd1: begin
                coef_sel[0] = C709_R;
                coef_sel[1] = C709_G;
                coef_sel[2] = C709_B;
            end
            2'd2: begin
                coef_sel[0] = CAVG;
                coef_sel[1] = CAVG;
                coef_sel[2] = CAVG;
            end
            default: begin
                coef_sel[0] = cust_coef[0];
                coef_sel[1] = cust_coef[1];
                coef_sel[2] = cust_coef[2];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel datapath: custom weight register, S1 capture, S2 product
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [COEF_WIDTH-1:0] cust_reg;
            logic [PIX_WIDTH-1:0]  pix_reg;
            logic [COEF_WIDTH-1:0] coef_reg;
            logic [PROD_W-1:0]     prod_reg;

            // Custom weights load on cfg_we independent of the stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cust_reg <= '0;
                end else if (cfg_we) begin
                    cust_reg <= cfg_coef[gi];
                end
            end

            // S1: only real pixels are captured; bubbles leave data alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pix_reg  <= '0;
                    coef_reg <= '0;
                end else if (advance && din_valid) begin
                    pix_reg  <= din_pix[gi];
                    coef_reg <= coef_sel[gi];
                end
            end

            // S2: full-width product, no truncation before the sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_reg <= '0;
                end else if (advance && s1_valid_reg) begin
                    prod_reg <= PROD_W'(pix_reg) * PROD_W'(coef_reg);
                end
            end

            assign cust_coef[gi] = cust_reg;
            assign prod_bus[gi]  = prod_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S3 combinational: sum, round to nearest, scale, clamp
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]     sum_rounded;
    logic [SUM_W-1:0]     sum_scaled;
    logic [PIX_WIDTH-1:0] gray_next;
    logic                 sat_next;

    always_comb begin
        sum_rounded = SUM_W'(prod_bus[0]) + SUM_W'(prod_bus[1])
                    + SUM_W'(prod_bus[2]) + ROUND_BIAS;
        sum_scaled  = sum_rounded >> COEF_WIDTH;
        gray_next   = sum_scaled[PIX_WIDTH-1:0];
        sat_next    = 1'b0;
        // Custom weights may sum above 1.0; clamp rather than wrap.
        if (sum_scaled > PIX_MAX) begin
            gray_next = '1;
            sat_next  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage valids and output register
    // ------------------------------------------------------------------
    logic [PIX_WIDTH-1:0] gray_reg;
    logic                 sat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s2_valid_reg   <= 1'b0;
            dout_valid_reg <= 1'b0;
            gray_reg       <= '0;
            sat_reg        <= 1'b0;
        end else if (advance) begin
            s1_valid_reg   <= din_valid;
            s2_valid_reg   <= s1_valid_reg;
            dout_valid_reg <= s2_valid_reg;
            // A bubble reaching the output leaves the last result visible
            // so the data lines stay quiet while dout_valid is low.
            if (s2_valid_reg) begin
                gray_reg <= gray_next;
                sat_reg  <= sat_next;
            end
        end
    end

    assign dout_valid = dout_valid_reg;
    assign grayscale  = gray_reg;
    assign dout_sat   = sat_reg;

endmodule
